voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of wavegen voices controlled; allowed 2..8.
REQ-002 Parameter INCR_WIDTH, default 8: phase-increment width per voice.
REQ-003 Parameter KEY_WIDTH, default 7: note key width.
REQ-004 Clock  input  1  sole clock; all state updates on posedge.
REQ-005 Reset  input  1  synchronous, active-high.
REQ-006 ReqValid  input  1  request present; held stable by the source until accepted.
REQ-007 ReqReady  output  1  allocator can accept a request this cycle.
REQ-008 ReqOn  input  1  1 = note-on, 0 = note-off.
REQ-009 ReqKey  input  KEY_WIDTH  note key.
REQ-010 ReqIncr  input  INCR_WIDTH  phase increment for note-on; ignored for note-off.
REQ-011 VoiceGate  output  NUM_VOICES  per-voice gate; bit i drives Gate of wavegen i.
REQ-012 VoiceIncr  output  NUM_VOICES*INCR_WIDTH  packed increments; voice i at [i*INCR_WIDTH +: INCR_WIDTH].
REQ-013 VoiceKey  output  NUM_VOICES*KEY_WIDTH  packed key currently bound to each voice.
REQ-014 StealPulse  output  1  one-cycle pulse when a note-on steals a gated voice.
REQ-015 MissPulse  output  1  one-cycle pulse when a note-off matches no gated voice.

Function
REQ-016 States: IDLE, SCAN, APPLY, GAP; ReqReady SHALL be 1 only in IDLE.
REQ-017 Accept = ReqValid & ReqReady at a posedge; ReqOn/ReqKey/ReqIncr latched at that edge; IDLE -> SCAN.
REQ-018 SCAN SHALL examine exactly one voice per cycle, index 0 to NUM_VOICES-1, then go to APPLY (SCAN lasts NUM_VOICES cycles).
REQ-019 Note-on target priority: (a) lowest-index gated voice with VoiceKey == key (retrigger); else (b) lowest-index ungated voice; else (c) gated voice with largest age, ties to lowest index (steal).
REQ-020 Note-off target: lowest-index gated voice with VoiceKey == key; if none, no voice changes.
REQ-021 APPLY, free-voice note-on: gate<=1, incr<=ReqIncr, key<=ReqKey, age<=0; next state IDLE.
REQ-022 APPLY, retrigger or steal: gate<=0, incr/key/age written as REQ-021; next state GAP; GAP sets gate<=1 and returns to IDLE.
REQ-023 APPLY, note-off with match: gate<=0; incr and key held (release tail); next state IDLE.
REQ-024 APPLY, note-off without match: MissPulse=1 for that cycle; next state IDLE.
REQ-025 Age: per-voice 8-bit counter; on every note-on APPLY, every gated voice other than the target increments, saturating at 255.
REQ-026 StealPulse SHALL be 1 exactly during the APPLY cycle of a steal (case c), 0 otherwise.
REQ-027 Latency from accept edge: free-voice note-on and note-off outputs update at edge NUM_VOICES+1; retrigger/steal gate is low after edge NUM_VOICES+1 and high after edge NUM_VOICES+2.
REQ-028 ReqReady returns high in the cycle after the last state update (after APPLY, or after GAP).
REQ-029 ReqValid while ReqReady=0 SHALL have no effect; no request is queued.
REQ-030 Voice outputs SHALL be registered; no combinational path from Req* to Voice*.

Reset
REQ-031 Reset SHALL force IDLE from any state, including mid-SCAN/APPLY/GAP; in-flight requests are discarded.
REQ-032 Reset values: VoiceGate=0, VoiceIncr=0, VoiceKey=0, all ages=0, StealPulse=0, MissPulse=0; ReqReady=1 on the first cycle after Reset deasserts.

Verification (NUM_VOICES=4)
REQ-033 Reset 2 cycles -> VoiceGate=4'b0000, VoiceIncr=0, ReqReady=1, pulses 0.
REQ-034 Note-on key 60 incr 0x0F accepted at edge 0 -> ReqReady low for 5 cycles; after edge 5, VoiceGate=0001, VoiceIncr[7:0]=0x0F, VoiceKey[6:0]=60.
REQ-035 Note-ons keys 60,61,62,63 then 64 -> fifth steals voice 0: StealPulse for 1 cycle, gate0 low 1 cycle then high, VoiceKey voice0=64.
REQ-036 With keys 60..63 gated, note-off 62 -> VoiceGate=1011, voice2 incr held; then note-off 99 -> MissPulse 1 cycle, gates unchanged.
REQ-037 Note-on key 61 incr 0x20 while 61 gated on voice1 -> voice1 gate drops 1 cycle, incr=0x20, StealPulse stays 0, other gates unchanged.
REQ-038 Reset asserted 2 cycles after a note-on accept (mid-SCAN) -> all outputs at reset values, request not applied, ReqReady=1 after release.

Source files
------------

// File: rtl/voice_allocator.sv
// Voice allocator: binds note-on/note-off requests to wavegen voices.
// A sequential scan picks the retrigger, free or oldest voice; retrigger and steal insert a one-cycle gate gap.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int INCR_WIDTH = 8,
    parameter int KEY_WIDTH  = 7
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             ReqValid,
    output logic                             ReqReady,
    input  logic                             ReqOn,
    input  logic [KEY_WIDTH-1:0]             ReqKey,
    input  logic [INCR_WIDTH-1:0]            ReqIncr,
    output logic [NUM_VOICES-1:0]            VoiceGate,
    output logic [NUM_VOICES*INCR_WIDTH-1:0] VoiceIncr,
    output logic [NUM_VOICES*KEY_WIDTH-1:0]  VoiceKey,
    output logic                             StealPulse,
    output logic                             MissPulse
);

    // state | meaning
    // IDLE  | ready, waiting for a request
    // SCAN  | examine one voice per cycle
    // APPLY | write the chosen voice (or report a miss)
    // GAP   | re-raise the gate after a retrigger or steal

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, APPLY, GAP} state_t;

    state_t state, state_nxt;

    logic [NUM_VOICES-1:0]                 voice_gate;
    logic [NUM_VOICES-1:0][INCR_WIDTH-1:0] voice_incr;
    logic [NUM_VOICES-1:0][KEY_WIDTH-1:0]  voice_key;
    logic [NUM_VOICES-1:0][7:0]            voice_age;

    logic                  req_on;
    logic [KEY_WIDTH-1:0]  req_key;
    logic [INCR_WIDTH-1:0] req_incr;

    logic [IDX_W-1:0] scan_idx;
    logic             match_found, free_found, old_found;
    logic [IDX_W-1:0] match_idx, free_idx, old_idx;
    logic [7:0]       old_age;

    logic             take_free;
    logic [IDX_W-1:0] tgt_idx;

    assign take_free = !match_found && free_found;
    assign tgt_idx   = match_found ? match_idx : (free_found ? free_idx : old_idx);

    assign VoiceGate = voice_gate;
    assign VoiceIncr = voice_incr;
    assign VoiceKey  = voice_key;

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ReqReady   = 1'b0;
        StealPulse = 1'b0;
        MissPulse  = 1'b0;
        case (state)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) state_nxt = SCAN;
            end
            SCAN: begin
                if (scan_idx == LAST_IDX) state_nxt = APPLY;
            end
            APPLY: begin
                if (req_on) begin
                    StealPulse = !match_found && !free_found;
                    state_nxt  = take_free ? IDLE : GAP;
                end else begin
                    MissPulse = !match_found;
                    state_nxt = IDLE;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            voice_gate  <= '0;
            voice_incr  <= '0;
            voice_key   <= '0;
            voice_age   <= '0;
            req_on      <= 1'b0;
            req_key     <= '0;
            req_incr    <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        req_on      <= ReqOn;
                        req_key     <= ReqKey;
                        req_incr    <= ReqIncr;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                        old_age     <= '0;
                    end
                end
                SCAN: begin
                    scan_idx <= scan_idx + 1'b1;
                    if (voice_gate[scan_idx]) begin
                        if (!match_found && voice_key[scan_idx] == req_key) begin
                            match_found <= 1'b1;
                            match_idx   <= scan_idx;
                        end
                        // strict greater-than keeps the lowest index on equal ages
                        if (!old_found || voice_age[scan_idx] > old_age) begin
                            old_found <= 1'b1;
                            old_idx   <= scan_idx;
                            old_age   <= voice_age[scan_idx];
                        end
                    end else if (!free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                end
                APPLY: begin
                    if (req_on) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == tgt_idx) begin
                                voice_gate[i] <= take_free;
                                voice_incr[i] <= req_incr;
                                voice_key[i]  <= req_key;
                                voice_age[i]  <= 8'd0;
                            end else if (voice_gate[i] && voice_age[i] != 8'hFF) begin
                                voice_age[i] <= voice_age[i] + 8'd1;
                            end
                        end
                    end else if (match_found) begin
                        voice_gate[match_idx] <= 1'b0;
                    end
                end
                GAP:     voice_gate[tgt_idx] <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed and random requests against a
// behavioural voice-pool model, checked by a scoreboard monitor at transaction completion.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int IW = 8;
    localparam int KW = 7;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic ReqValid = 1'b0;
    logic ReqOn = 1'b0;
    logic [KW-1:0] ReqKey = '0;
    logic [IW-1:0] ReqIncr = '0;
    logic ReqReady;
    logic [NV-1:0] VoiceGate;
    logic [NV*IW-1:0] VoiceIncr;
    logic [NV*KW-1:0] VoiceKey;
    logic StealPulse;
    logic MissPulse;

    voice_allocator #(.NUM_VOICES(NV), .INCR_WIDTH(IW), .KEY_WIDTH(KW)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOn(ReqOn), .ReqKey(ReqKey), .ReqIncr(ReqIncr),
        .VoiceGate(VoiceGate), .VoiceIncr(VoiceIncr), .VoiceKey(VoiceKey),
        .StealPulse(StealPulse), .MissPulse(MissPulse)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [NV-1:0]    gate;
        logic [NV*IW-1:0] incr;
        logic [NV*KW-1:0] key;
        int               lat;
        int               steal;
        int               miss;
        logic [NV-1:0]    dip;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    bit m_gate[NV];
    int m_key[NV];
    int m_incr[NV];
    int m_age[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_key[i] = 0; m_incr[i] = 0; m_age[i] = 0;
        end
    endfunction

    function automatic exp_t model_apply(bit on, int k, int inc);
        exp_t e;
        int t = -1;
        bit gap = 0;
        e.steal = 0;
        e.miss = 0;
        for (int i = 0; i < NV; i++)
            if (t < 0 && m_gate[i] && m_key[i] == k) t = i;
        if (on) begin
            if (t >= 0) gap = 1;
            else begin
                for (int i = 0; i < NV; i++)
                    if (t < 0 && !m_gate[i]) t = i;
                if (t < 0) begin
                    int best = 0;
                    for (int i = 1; i < NV; i++)
                        if (m_age[i] > m_age[best]) best = i;
                    t = best;
                    gap = 1;
                    e.steal = 1;
                end
            end
            for (int i = 0; i < NV; i++)
                if (i != t && m_gate[i]) m_age[i] = (m_age[i] >= 255) ? 255 : m_age[i] + 1;
            m_gate[t] = 1; m_key[t] = k; m_incr[t] = inc; m_age[t] = 0;
        end else if (t >= 0) begin
            m_gate[t] = 0;
        end else begin
            e.miss = 1;
        end
        e.lat = gap ? 6 : 5;
        for (int i = 0; i < NV; i++) begin
            e.gate[i] = m_gate[i];
            e.incr[i*IW +: IW] = IW'(m_incr[i]);
            e.key[i*KW +: KW] = KW'(m_key[i]);
        end
        e.dip = e.gate;
        if (gap) e.dip[t] = 1'b0;
        return e;
    endfunction

    // Monitor: a transaction completes when ReqReady returns high after a busy stretch.
    int busy = 0, st_cnt = 0, ms_cnt = 0;
    logic [NV-1:0] dip_seen = '0;
    always @(negedge Clock) begin
        if (Reset) begin
            busy = 0; st_cnt = 0; ms_cnt = 0;
        end else begin
            st_cnt += int'(StealPulse);
            ms_cnt += int'(MissPulse);
            if (!ReqReady) begin
                busy++;
                if (busy == 6) dip_seen = VoiceGate;
            end else if (busy > 0) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_txn actual=completion required=none at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("gate", 64'(VoiceGate), 64'(e.gate));
                    chk("incr", 64'(VoiceIncr), 64'(e.incr));
                    chk("key", 64'(VoiceKey), 64'(e.key));
                    chk("busy_cycles", 64'(busy), 64'(e.lat));
                    chk("steal_pulses", 64'(st_cnt), 64'(e.steal));
                    chk("miss_pulses", 64'(ms_cnt), 64'(e.miss));
                    if (e.lat == 6) chk("gap_gate", 64'(dip_seen), 64'(e.dip));
                end
                busy = 0; st_cnt = 0; ms_cnt = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge Clock);
        while (!ReqReady && n < 20) begin
            @(negedge Clock);
            n++;
        end
        if (!ReqReady) begin
            checks++; errors++;
            $display("FAIL ready_timeout actual=0 required=1 at %0t", $time);
        end
    endtask

    task automatic do_req(input bit on, input int k, input int inc, input bit poke);
        wait_ready();
        ReqValid = 1'b1; ReqOn = on; ReqKey = KW'(k); ReqIncr = IW'(inc);
        @(posedge Clock);
        sb.push_back(model_apply(on, k, inc));
        #1;
        ReqValid = 1'b0;
        ReqIncr = IW'($urandom);
        ReqKey = KW'($urandom);
        if (poke) begin
            @(negedge Clock);
            ReqValid = 1'b1; ReqOn = 1'($urandom);
            @(negedge Clock);
            @(negedge Clock);
            ReqValid = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_gate"}, 64'(VoiceGate), 64'd0);
        chk({tag, "_incr"}, 64'(VoiceIncr), 64'd0);
        chk({tag, "_key"}, 64'(VoiceKey), 64'd0);
        chk({tag, "_ready"}, 64'(ReqReady), 64'd1);
        chk({tag, "_pulses"}, 64'({StealPulse, MissPulse}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check_reset_values("reset");

        do_req(1, 60, 'h0F, 0);
        do_req(1, 61, 'h11, 0);
        do_req(1, 62, 'h12, 1);
        do_req(1, 63, 'h13, 0);
        do_req(0, 62, 'h00, 0);
        do_req(0, 99, 'h00, 0);
        do_req(1, 61, 'h20, 0);
        do_req(1, 65, 'h15, 0);
        do_req(1, 64, 'h14, 0);

        // reset lands mid-SCAN of an accepted note-on
        wait_ready();
        ReqValid = 1'b1; ReqOn = 1'b1; ReqKey = KW'(70); ReqIncr = IW'('h33);
        @(posedge Clock);
        #1 ReqValid = 1'b0;
        @(posedge Clock);
        #1 Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        model_reset();
        @(negedge Clock);
        check_reset_values("midscan");

        for (int n = 0; n < 400; n++) begin
            bit on;
            on = ($urandom_range(0, 9) < 6);
            do_req(on, 60 + int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   $urandom_range(0, 3) == 0);
        end

        wait_ready();
        repeat (2) @(negedge Clock);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
